jk_bank_arbiter: RTL

Round-robin arbiter and sequencer that shares a bank of NBITS JK-style bit registers among NREQ requesters. Each requester issues single-bit commands (hold, clear, set, toggle) through a valid/ready handshake. At most one command is applied per cycle. An optional lock lets one requester keep ownership for back-to-back commands. The block sits between control agents and the shared status/flag register bank and is the only writer of that bank.

---
 rtl/jk_arb_pkg.sv | 14 +
 rtl/jk_bank_arbiter_rr_pick.sv | 24 ++
 rtl/jk_bank_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/jk_arb_pkg.sv
// Shared encodings for the JK bank arbiter: {j,k} op codes and arbiter FSM states.
package jk_arb_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } arb_state_t;

endpackage

// File: rtl/jk_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant for the first valid bit at or after ptr.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && valid[(32'(ptr) + k) % NREQ]) begin
                grant[(32'(ptr) + k) % NREQ] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter/sequencer that is the sole writer of a shared JK bit bank.
// Optional JK_ARB_TOGGLE_CNT_EN adds a saturating count of applied in-range toggles.
module jk_bank_arbiter
    import jk_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned NBITS = 8,
    parameter int unsigned IDXW  = (NBITS > 1) ? $clog2(NBITS) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NREQ-1:0]                       req_valid,
    output logic [NREQ-1:0]                       req_ready,
    input  logic [NREQ*IDXW-1:0]                  req_idx,
    input  logic [NREQ*2-1:0]                     req_op,
    input  logic [NREQ-1:0]                       req_lock,
    output logic [NBITS-1:0]                      q,
    output logic                                  done,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] done_id,
`ifdef JK_ARB_TOGGLE_CNT_EN
    output logic [15:0]                           toggle_cnt,
`endif
    output logic                                  err
);

    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state, state_nx;
    logic [IDW-1:0]  rr_ptr, owner, win, ptr_nx;
    logic [IDW-1:0]  win_inc, owner_inc;
    logic [NREQ-1:0] pick, ready;
    logic            hs, wlock, inrange, ptr_ld, owner_ld;
    logic [IDXW-1:0] widx;
    logic [1:0]      wop;

    rr_pick #(.NREQ(NREQ), .PW(IDW)) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (pick)
    );

    // Ready depends only on valid/state/pointer/owner, never on the command payload.
    always_comb begin
        ready = '0;
        if (state == ST_IDLE) begin
            ready = pick;
        end else begin
            ready[owner] = req_valid[owner];
        end
    end

    assign req_ready = ready;

    always_comb begin
        win = '0;
        for (int unsigned r = 0; r < NREQ; r++) begin
            if (ready[r]) win = IDW'(r);
        end
    end

    assign hs        = |(ready & req_valid);
    assign widx      = req_idx[win*IDXW +: IDXW];
    assign wop       = req_op[win*2 +: 2];
    assign wlock     = req_lock[win];
    assign inrange   = (32'(widx) < NBITS);
    assign win_inc   = (32'(win) == NREQ - 1) ? '0 : win + 1'b1;
    assign owner_inc = (32'(owner) == NREQ - 1) ? '0 : owner + 1'b1;

    always_comb begin
        state_nx = state;
        ptr_ld   = 1'b0;
        ptr_nx   = rr_ptr;
        owner_ld = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hs) begin
                    ptr_ld = 1'b1;
                    ptr_nx = win_inc;
                    if (wlock) begin
                        state_nx = ST_LOCKED;
                        owner_ld = 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                // Owner dropping valid spends this cycle grant-free and releases the lock.
                if (!req_valid[owner] || !wlock) begin
                    state_nx = ST_IDLE;
                    ptr_ld   = 1'b1;
                    ptr_nx   = owner_inc;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            q       <= '0;
            done    <= 1'b0;
            done_id <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nx;
            if (ptr_ld)   rr_ptr <= ptr_nx;
            if (owner_ld) owner  <= win;
            done <= hs;
            err  <= hs && !inrange;
            if (hs) done_id <= win;
            if (hs && inrange) begin
                case (wop)
                    JK_CLR:  q[widx] <= 1'b0;
                    JK_SET:  q[widx] <= 1'b1;
                    JK_TGL:  q[widx] <= ~q[widx];
                    default: q[widx] <= q[widx];
                endcase
            end
        end
    end

`ifdef JK_ARB_TOGGLE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            toggle_cnt <= '0;
        end else if (hs && inrange && wop == JK_TGL && toggle_cnt != '1) begin
            toggle_cnt <= toggle_cnt + 16'd1;
        end
    end
`endif

endmodule
